// File: rtl/spec_busy_table_pkg.sv
// Shared types and default sizing for the speculative physical-register busy table.
package spec_busy_table_pkg;

    typedef enum logic [1:0] {
        BT_READY = 2'd0,
        BT_BUSY  = 2'd1,
        BT_PEND  = 2'd2
    } bt_state_e;

    localparam int BT_PREG_NUM   = 128;
    localparam int BT_RD_PORTS   = 8;
    localparam int BT_DIS_PORTS  = 4;
    localparam int BT_WB_PORTS   = 4;
    localparam int BT_WAKE_PORTS = 2;
    localparam int BT_WALK_PORTS = 4;
    localparam int BT_LAT_W      = 2;
    localparam int BT_BYPASS     = 1;
    localparam int BT_ZERO_READY = 1;

endpackage

// File: rtl/spec_busy_table_entry.sv
// One busy-table entry: READY/BUSY/PENDING state with a wakeup countdown,
// driven by already-decoded, already-prioritised hit strobes.
module bt_entry
    import spec_busy_table_pkg::*;
#(
    parameter int LAT_W = BT_LAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_dis_hit,
    input  logic             i_rdy_hit,
    input  logic             i_cancel_hit,
    input  logic             i_wake_hit,
    input  logic [LAT_W-1:0] i_wake_lat,
    output logic             o_ready
);

    bt_state_e        r_state;
    bt_state_e        w_nxt_state;
    logic [LAT_W-1:0] r_cnt;
    logic [LAT_W-1:0] w_nxt_cnt;
    logic             w_wake_ok;

    // A wake only lands on a BUSY entry; READY/PENDING keep the first wake.
    assign w_wake_ok = i_wake_hit && (r_state == BT_BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BT_READY;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        if (i_dis_hit) begin
            w_nxt_state = BT_BUSY;
            w_nxt_cnt   = '0;
        end else if (i_rdy_hit) begin
            w_nxt_state = BT_READY;
            w_nxt_cnt   = '0;
        end else if (i_cancel_hit && ((r_state == BT_PEND) || w_wake_ok)) begin
            w_nxt_state = BT_BUSY;
            w_nxt_cnt   = '0;
        end else if (w_wake_ok) begin
            if (i_wake_lat == '0) begin
                w_nxt_state = BT_READY;
            end else begin
                w_nxt_state = BT_PEND;
                w_nxt_cnt   = i_wake_lat;
            end
        end else if (r_state == BT_PEND) begin
            if (r_cnt <= LAT_W'(1)) begin
                w_nxt_state = BT_READY;
                w_nxt_cnt   = '0;
            end else begin
                w_nxt_cnt   = r_cnt - LAT_W'(1);
            end
        end
    end

    assign o_ready = (r_state == BT_READY);

endmodule

// File: rtl/spec_busy_table.sv
// Physical-register busy table with speculative delayed wakeup, load-miss cancel,
// rollback restore and optional same-cycle writeback forwarding to lookups.
module spec_busy_table
    import spec_busy_table_pkg::*;
#(
    parameter int PREG_NUM   = BT_PREG_NUM,
    parameter int RD_PORTS   = BT_RD_PORTS,
    parameter int DIS_PORTS  = BT_DIS_PORTS,
    parameter int WB_PORTS   = BT_WB_PORTS,
    parameter int WAKE_PORTS = BT_WAKE_PORTS,
    parameter int WALK_PORTS = BT_WALK_PORTS,
    parameter int LAT_W      = BT_LAT_W,
    parameter int BYPASS     = BT_BYPASS,
    parameter int ZERO_READY = BT_ZERO_READY,
    localparam int PW        = $clog2(PREG_NUM)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DIS_PORTS-1:0]                dis_en,
    input  logic [DIS_PORTS-1:0][PW-1:0]        dis_rd,
    input  logic                                redirect,
    input  logic [RD_PORTS-1:0][PW-1:0]         rd_preg,
    output logic [RD_PORTS-1:0]                 rd_ready,
    input  logic [WB_PORTS-1:0]                 wb_en,
    input  logic [WB_PORTS-1:0]                 wb_we,
    input  logic [WB_PORTS-1:0][PW-1:0]         wb_rd,
    input  logic [WAKE_PORTS-1:0]               wake_en,
    input  logic [WAKE_PORTS-1:0][PW-1:0]       wake_rd,
    input  logic [WAKE_PORTS-1:0][LAT_W-1:0]    wake_lat,
    input  logic [WAKE_PORTS-1:0]               cancel_en,
    input  logic [WAKE_PORTS-1:0][PW-1:0]       cancel_rd,
    input  logic                                walk,
    input  logic [WALK_PORTS-1:0]               walk_we,
    input  logic [WALK_PORTS-1:0][PW-1:0]       walk_prd
);

    // Entry 0 never sees events when it is the hard-wired zero register.
    localparam logic [PREG_NUM-1:0] EVT_MASK =
        (ZERO_READY != 0) ? {{(PREG_NUM-1){1'b1}}, 1'b0} : {PREG_NUM{1'b1}};

    logic [PREG_NUM-1:0]            w_dis_vec;
    logic [PREG_NUM-1:0]            w_wb_vec;
    logic [PREG_NUM-1:0]            w_walk_vec;
    logic [PREG_NUM-1:0]            w_cancel_vec;
    logic [PREG_NUM-1:0]            w_wake_vec;
    logic [PREG_NUM-1:0][LAT_W-1:0] w_wake_lat;
    logic [PREG_NUM-1:0]            w_ready_vec;

    function automatic logic [PREG_NUM-1:0] f_dec(input logic en, input logic [PW-1:0] idx);
        logic [PREG_NUM-1:0] v;
        v      = '0;
        v[idx] = en;
        return v;
    endfunction

    always_comb begin
        w_dis_vec    = '0;
        w_wb_vec     = '0;
        w_walk_vec   = '0;
        w_cancel_vec = '0;
        w_wake_vec   = '0;
        w_wake_lat   = '0;
        for (int p = 0; p < DIS_PORTS; p++)
            w_dis_vec = w_dis_vec | f_dec(dis_en[p] & ~redirect, dis_rd[p]);
        for (int p = 0; p < WB_PORTS; p++)
            w_wb_vec = w_wb_vec | f_dec(wb_en[p] & wb_we[p], wb_rd[p]);
        for (int p = 0; p < WALK_PORTS; p++)
            w_walk_vec = w_walk_vec | f_dec(walk & walk_we[p], walk_prd[p]);
        for (int p = 0; p < WAKE_PORTS; p++) begin
            w_cancel_vec = w_cancel_vec | f_dec(cancel_en[p], cancel_rd[p]);
            w_wake_vec   = w_wake_vec | f_dec(wake_en[p], wake_rd[p]);
        end
        // Walk ports high to low so the lowest-indexed wake's latency sticks.
        for (int p = WAKE_PORTS - 1; p >= 0; p--) begin
            if (wake_en[p])
                w_wake_lat[wake_rd[p]] = wake_lat[p];
        end
    end

    for (genvar e = 0; e < PREG_NUM; e++) begin : g_ent
        bt_entry #(
            .LAT_W (LAT_W)
        ) u_ent (
            .clk          (clk),
            .rst          (rst),
            .i_dis_hit    (w_dis_vec[e] & EVT_MASK[e]),
            .i_rdy_hit    ((w_wb_vec[e] | w_walk_vec[e]) & EVT_MASK[e]),
            .i_cancel_hit (w_cancel_vec[e] & EVT_MASK[e]),
            .i_wake_hit   (w_wake_vec[e] & EVT_MASK[e]),
            .i_wake_lat   (w_wake_lat[e]),
            .o_ready      (w_ready_vec[e])
        );
    end

    always_comb begin
        rd_ready = '0;
        for (int i = 0; i < RD_PORTS; i++)
            rd_ready[i] = w_ready_vec[rd_preg[i]] | ((BYPASS != 0) & w_wb_vec[rd_preg[i]]);
    end

endmodule

// File: tb/tb_spec_busy_table.sv
// Self-checking bench: per-cycle vector table plus hand sequences, with lookup
// expectations queued at drive time and compared mid-cycle.
module tb_spec_busy_table;

    localparam int PREG = 128;
    localparam int RDP  = 8;
    localparam int DISP = 4;
    localparam int WBP  = 4;
    localparam int WKP  = 2;
    localparam int WLKP = 4;
    localparam int LW   = 2;
    localparam int PW   = 7;
    localparam int NV   = 25;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [DISP-1:0]           dis_en;
    logic [DISP-1:0][PW-1:0]   dis_rd;
    logic                      redirect;
    logic [RDP-1:0][PW-1:0]    rd_preg;
    logic [RDP-1:0]            rd_ready;
    logic [WBP-1:0]            wb_en, wb_we;
    logic [WBP-1:0][PW-1:0]    wb_rd;
    logic [WKP-1:0]            wake_en, cancel_en;
    logic [WKP-1:0][PW-1:0]    wake_rd, cancel_rd;
    logic [WKP-1:0][LW-1:0]    wake_lat;
    logic                      walk;
    logic [WLKP-1:0]           walk_we;
    logic [WLKP-1:0][PW-1:0]   walk_prd;

    spec_busy_table dut (
        .clk(clk), .rst(rst), .dis_en(dis_en), .dis_rd(dis_rd), .redirect(redirect),
        .rd_preg(rd_preg), .rd_ready(rd_ready), .wb_en(wb_en), .wb_we(wb_we), .wb_rd(wb_rd),
        .wake_en(wake_en), .wake_rd(wake_rd), .wake_lat(wake_lat),
        .cancel_en(cancel_en), .cancel_rd(cancel_rd),
        .walk(walk), .walk_we(walk_we), .walk_prd(walk_prd)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    port;
        int    preg;
        bit    exp;
        string name;
    } exp_t;

    typedef struct {
        bit dis; int dp; bit rdr;
        bit wb;  int wp;
        bit wk;  int kp; int kl;
        bit cn;  int cp;
        bit wl;  int lp;
        int q0;  bit e0;
        int q1;  bit e1;
    } vec_t;

    exp_t sb[$];
    vec_t tv[NV];
    int   errors = 0;
    int   checks = 0;

    task automatic clr();
        dis_en = '0; dis_rd = '0; redirect = 1'b0; rd_preg = '0;
        wb_en = '0; wb_we = '0; wb_rd = '0;
        wake_en = '0; wake_rd = '0; wake_lat = '0;
        cancel_en = '0; cancel_rd = '0;
        walk = 1'b0; walk_we = '0; walk_prd = '0;
    endtask

    task automatic look(input int port, input int preg, input bit exp, input string name);
        rd_preg[port] = PW'(preg);
        sb.push_back('{port, preg, exp, name});
    endtask

    // Compare queued lookups at the falling edge, then advance one cycle.
    task automatic tick();
        @(negedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (rd_ready[e.port] !== e.exp) begin
                errors++;
                $display("FAIL %s: preg %0d rd_ready=%b expected %b", e.name, e.preg,
                         rd_ready[e.port], e.exp);
            end
        end
        @(posedge clk);
        #1;
        clr();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        vec_t v;
        tv[0]  = '{0,0,0,   0,0,   0,0,0,   0,0,   0,0,   0,1,   5,1};
        tv[1]  = '{1,5,0,   0,0,   0,0,0,   0,0,   0,0,   127,1, 5,1};
        tv[2]  = '{1,9,0,   0,0,   0,0,0,   0,0,   0,0,   5,0,   9,1};
        tv[3]  = '{1,12,0,  0,0,   0,0,0,   0,0,   0,0,   5,0,   9,0};
        tv[4]  = '{0,0,0,   1,5,   1,9,2,   0,0,   0,0,   5,1,   12,0};
        tv[5]  = '{0,0,0,   0,0,   1,9,0,   0,0,   0,0,   5,1,   9,0};
        tv[6]  = '{0,0,0,   0,0,   0,0,0,   0,0,   0,0,   9,0,   12,0};
        tv[7]  = '{0,0,0,   0,0,   1,12,3,  0,0,   0,0,   9,1,   12,0};
        tv[8]  = '{0,0,0,   0,0,   0,0,0,   0,0,   0,0,   9,1,   12,0};
        tv[9]  = '{0,0,0,   0,0,   0,0,0,   1,12,  0,0,   12,0,  9,1};
        for (int i = 10; i < 18; i++)
            tv[i] = '{0,0,0, 0,0, 0,0,0, 0,0, 0,0, 12,0, 12,0};
        tv[18] = '{0,0,0,   1,12,  0,0,0,   0,0,   0,0,   12,1,  9,1};
        tv[19] = '{1,20,0,  1,20,  0,0,0,   0,0,   0,0,   12,1,  20,1};
        tv[20] = '{1,21,1,  0,0,   0,0,0,   0,0,   0,0,   20,0,  21,1};
        tv[21] = '{1,30,0,  0,0,   0,0,0,   0,0,   0,0,   21,1,  30,1};
        tv[22] = '{0,0,0,   0,0,   0,0,0,   0,0,   1,30,  30,0,  21,1};
        tv[23] = '{1,0,0,   0,0,   0,0,0,   0,0,   0,0,   30,1,  0,1};
        tv[24] = '{0,0,0,   0,0,   0,0,0,   0,0,   0,0,   0,1,   31,1};

        clr();
        repeat (2) @(posedge clk);
        #1;
        look(0, 0, 1'b1, "in_reset.p0");
        look(1, 77, 1'b1, "in_reset.p77");
        look(2, 127, 1'b1, "in_reset.p127");
        tick();
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            v = tv[i];
            dis_en[0] = v.dis;  dis_rd[0] = PW'(v.dp);  redirect = v.rdr;
            wb_en[0] = v.wb;    wb_we[0] = v.wb;        wb_rd[0] = PW'(v.wp);
            wake_en[0] = v.wk;  wake_rd[0] = PW'(v.kp); wake_lat[0] = LW'(v.kl);
            cancel_en[0] = v.cn; cancel_rd[0] = PW'(v.cp);
            walk = v.wl;        walk_we[0] = v.wl;      walk_prd[0] = PW'(v.lp);
            look(0, v.q0, v.e0, $sformatf("vec%0d.a", i));
            look(1, v.q1, v.e1, $sformatf("vec%0d.b", i));
            tick();
        end

        // Two wake ports on one preg: port 0 (lat 3) must win over port 1 (lat 1).
        dis_en[1:0] = 2'b11; dis_rd[0] = PW'(40); dis_rd[1] = PW'(40);
        tick();
        wake_en = 2'b11; wake_rd[0] = PW'(40); wake_lat[0] = LW'(3);
        wake_rd[1] = PW'(40); wake_lat[1] = LW'(1);
        look(0, 40, 1'b0, "wprio.T");
        tick();
        look(0, 40, 1'b0, "wprio.T1"); tick();
        look(0, 40, 1'b0, "wprio.T2"); tick();
        look(0, 40, 1'b0, "wprio.T3"); tick();
        look(0, 40, 1'b1, "wprio.T4"); tick();

        // Cancel in the same cycle as a zero-latency wake keeps the entry busy.
        dis_en[0] = 1'b1; dis_rd[0] = PW'(41);
        tick();
        wake_en[0] = 1'b1; wake_rd[0] = PW'(41); wake_lat[0] = '0;
        cancel_en[1] = 1'b1; cancel_rd[1] = PW'(41);
        look(0, 41, 1'b0, "wcan.T");
        tick();
        look(0, 41, 1'b0, "wcan.T1"); tick();
        look(0, 41, 1'b0, "wcan.T2"); tick();

        // Cancel on READY and on plain BUSY does nothing; a later wake still works.
        cancel_en[0] = 1'b1; cancel_rd[0] = PW'(42); dis_en[0] = 1'b1; dis_rd[0] = PW'(43);
        look(0, 42, 1'b1, "can_rdy.T");
        tick();
        cancel_en[0] = 1'b1; cancel_rd[0] = PW'(43);
        look(0, 42, 1'b1, "can_rdy.T1");
        look(1, 43, 1'b0, "can_busy.T");
        tick();
        wake_en[1] = 1'b1; wake_rd[1] = PW'(43); wake_lat[1] = LW'(1);
        look(0, 43, 1'b0, "can_busy.wake");
        tick();
        look(0, 43, 1'b0, "can_busy.w1"); tick();
        look(0, 43, 1'b1, "can_busy.w2"); tick();

        // Duplicate writeback ports OR together; wb_en without wb_we is no write.
        dis_en[1:0] = 2'b11; dis_rd[0] = PW'(44); dis_rd[1] = PW'(45);
        tick();
        wb_en = 4'b1110; wb_we = 4'b1100;
        wb_rd[1] = PW'(45); wb_rd[2] = PW'(44); wb_rd[3] = PW'(44);
        look(0, 44, 1'b1, "dupwb.byp44");
        look(1, 45, 1'b0, "dupwb.nowe45");
        tick();
        look(0, 44, 1'b1, "dupwb.reg44");
        look(1, 45, 1'b0, "dupwb.reg45");
        tick();

        // Reset asserted mid-wakeup with a dispatch in the reset cycle.
        dis_en[0] = 1'b1; dis_rd[0] = PW'(50);
        tick();
        wake_en[0] = 1'b1; wake_rd[0] = PW'(50); wake_lat[0] = LW'(3);
        look(0, 50, 1'b0, "rstmid.pre");
        tick();
        rst = 1'b1;
        dis_en[0] = 1'b1; dis_rd[0] = PW'(51);
        look(0, 50, 1'b1, "rstmid.r50");
        look(1, 51, 1'b1, "rstmid.r51");
        look(2, 45, 1'b1, "rstmid.r45");
        look(3, 41, 1'b1, "rstmid.r41");
        tick();
        rst = 1'b0;
        look(0, 50, 1'b1, "rstmid.a50");
        look(1, 51, 1'b1, "rstmid.a51");
        look(2, 45, 1'b1, "rstmid.a45");
        tick();
        for (int k = 0; k < 4; k++) begin
            look(0, 50, 1'b1, $sformatf("rstmid.hold%0d", k));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spec_busy_table.md
SPEC_BUSY_TABLE -- requirements
Module: spec_busy_table

Interface
REQ-001 Parameter PREG_NUM, default 128, number of physical registers (power of two).
REQ-002 Parameter RD_PORTS, default 8, number of readiness lookup ports.
REQ-003 Parameter DIS_PORTS, default 4, number of dispatch (allocate-busy) ports.
REQ-004 Parameter WB_PORTS, default 4, number of writeback ports.
REQ-005 Parameter WAKE_PORTS, default 2, number of speculative (delayed) wakeup and cancel ports.
REQ-006 Parameter WALK_PORTS, default 4, number of rollback walk ports.
REQ-007 Parameter LAT_W, default 2, width of wakeup latency field.
REQ-008 Parameter BYPASS, default 1, 1 = same-cycle writeback forwarded to lookups.
REQ-009 Parameter ZERO_READY, default 1, 1 = preg 0 permanently ready.
REQ-010 Derived: PW = clog2(PREG_NUM).
REQ-011 clk  in  1  single clock, rising edge.
REQ-012 rst  in  1  reset, asynchronous, active-high.
REQ-013 dis_en  in  DIS_PORTS  dispatch valid per port.
REQ-014 dis_rd  in  DIS_PORTS x PW  newly allocated destination preg.
REQ-015 redirect  in  1  backend redirect; suppresses dispatch this cycle.
REQ-016 rd_preg  in  RD_PORTS x PW  preg to look up.
REQ-017 rd_ready  out  RD_PORTS  1 = preg ready.
REQ-018 wb_en, wb_we  in  WB_PORTS each  writeback valid and register-write.
REQ-019 wb_rd  in  WB_PORTS x PW  writeback destination.
REQ-020 wake_en  in  WAKE_PORTS; wake_rd  in  WAKE_PORTS x PW; wake_lat  in  WAKE_PORTS x LAT_W  schedule ready after latency.
REQ-021 cancel_en  in  WAKE_PORTS; cancel_rd  in  WAKE_PORTS x PW  abort pending wakeup (load miss).
REQ-022 walk  in  1; walk_we  in  WALK_PORTS; walk_prd  in  WALK_PORTS x PW  rollback restore-ready.

Function
REQ-023 Each entry SHALL be in one of READY, BUSY, PENDING; PENDING holds a LAT_W-bit countdown cnt.
REQ-024 rd_ready[i] SHALL be 1 iff entry rd_preg[i] is READY, or (BYPASS=1 and some wb port has en&we with wb_rd==rd_preg[i] this cycle); lookups are combinational.
REQ-025 Dispatch hit (dis_en & ~redirect) SHALL force BUSY next cycle, overriding every other event on that entry.
REQ-026 Else writeback hit (en&we) or walk hit (walk&walk_we) SHALL force READY next cycle from any state.
REQ-027 Else cancel hit on a PENDING or newly-woken entry SHALL force BUSY, cnt cleared; cancel on READY/BUSY is ignored.
REQ-028 Else wake hit on BUSY entry: wake_lat==0 -> READY next cycle; wake_lat=L>0 -> PENDING, cnt=L.
REQ-029 Wake on READY or PENDING entry SHALL be ignored (first wake wins); multiple wake ports on one preg: lowest index wins.
REQ-030 PENDING with cnt==1 SHALL go READY next cycle; otherwise cnt decrements; wake at cycle T with latency L yields rd_ready=1 from cycle T+L+1.
REQ-031 Multiple dispatch ports naming the same preg SHALL be legal (result BUSY); duplicate wb/walk hits are OR-ed.
REQ-032 If ZERO_READY=1, entry 0 SHALL always read READY and ignore all events.

Reset
REQ-033 On rst assertion, asynchronously, all entries SHALL become READY with cnt=0; rd_ready reads 1 for every preg while rst is high.
REQ-034 Reset deassertion mid-wakeup SHALL leave no PENDING entries; no event in the reset cycle takes effect.

Structure
REQ-035 Shared package SHALL hold the entry state enum (READY/BUSY/PENDING) and default parameter constants.
REQ-036 A sub-module bt_entry SHALL implement one entry's state machine and countdown from decoded hit vectors; instantiated PREG_NUM times.
REQ-037 Top level SHALL decode each port into one-hot PREG_NUM vectors and OR-reduce per event class before feeding entries.

Verification
REQ-038 Reset, then lookup pregs 0,5,127 -> rd_ready=1,1,1.
REQ-039 Dispatch preg 5 at T -> rd_ready(5)=0 at T+1; wb preg 5 at T+3 -> 1 at T+3 (BYPASS=1), registered READY at T+4.
REQ-040 Busy preg 9, wake lat=2 at T -> rd_ready(9)=0 at T+1,T+2, =1 at T+3; second wake lat=0 at T+1 ignored.
REQ-041 Busy preg 12, wake lat=3 at T, cancel at T+2 -> preg 12 stays 0 through T+10; later wb restores 1.
REQ-042 Same cycle: dispatch and wb on preg 20 -> BUSY; redirect=1 with dispatch preg 21 -> preg 21 stays READY.
REQ-043 Dispatch preg 30, then walk with walk_we on preg 30 -> READY next cycle; dispatch preg 0 (ZERO_READY=1) -> stays READY.
